fsm_flow_control: RTL and testbench



---
 rtl/fsm_flow_control.sv | 159 +++++++++++++++
 tb/tb_fsm_flow_control.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_flow_control.sv
// Flow-control supervisor: manages shared FIFO thresholds and tracks idle, active and error status.
// Latency: every output is registered and changes on the rising clk edge after the inputs that cause it.
// Backpressure: none; inputs are sampled every cycle and ERROR is left only through reset_L.
//
// Ports:
//   clk, reset_L                 clock and asynchronous active-low reset
//   init                         level request to (re)load the thresholds
//   thr_high_in / thr_low_in     requested almost-full / almost-empty thresholds
//   fifo_empty / fifo_error      per-FIFO empty flags and error pulses (bit 0 = VC0, then VC1, D0, D1)
//   thr_high_out / thr_low_out   thresholds applied to all FIFOs
//   state                        one-hot state (RESET, INIT, IDLE, ACTIVE, ERROR)
//   idle_out/active_out/error_out  registered state decodes
//   error_fifo                   sticky record of the FIFOs that reported errors
module fsm_flow_control #(
  parameter int N_FIFO       = 4,
  parameter int THR_W        = 3,
  parameter int THR_HIGH_RST = 6,
  parameter int THR_LOW_RST  = 1,
  parameter int IDLE_CNT     = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [THR_W-1:0]  thr_high_in,
  input  logic [THR_W-1:0]  thr_low_in,
  input  logic [N_FIFO-1:0] fifo_empty,
  input  logic [N_FIFO-1:0] fifo_error,
  output logic [THR_W-1:0]  thr_high_out,
  output logic [THR_W-1:0]  thr_low_out,
  output logic [4:0]        state,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out,
  output logic [N_FIFO-1:0] error_fifo
);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t st;
  logic [3:0] cnt;

  logic             any_error;
  logic             all_empty;
  logic [THR_W-1:0] thr_low_clamped;
  logic [3:0]       cnt_next;

  assign state = st;

  always_comb begin
    any_error = |fifo_error;
    all_empty = &fifo_empty;
    // Never let the almost-empty threshold sit above the almost-full one.
    thr_low_clamped = (thr_low_in < thr_high_in) ? thr_low_in : thr_high_in;
    // Consecutive all-empty cycles, saturating so a long quiet spell cannot wrap.
    cnt_next = 4'd0;
    if (all_empty) begin
      cnt_next = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st           <= S_RESET;
      thr_high_out <= THR_W'(THR_HIGH_RST);
      thr_low_out  <= THR_W'(THR_LOW_RST);
      idle_out     <= 1'b0;
      active_out   <= 1'b0;
      error_out    <= 1'b0;
      error_fifo   <= '0;
      cnt          <= 4'd0;
    end else begin
      unique case (st)
        S_RESET: begin
          st <= S_INIT;
        end

        S_INIT: begin
          // Thresholds track the inputs on every edge spent in INIT,
          // including the edge that leaves it.
          thr_high_out <= thr_high_in;
          thr_low_out  <= thr_low_clamped;
          if (any_error) begin
            st         <= S_ERROR;
            error_out  <= 1'b1;
            error_fifo <= fifo_error;
          end else if (!init) begin
            st       <= S_IDLE;
            idle_out <= 1'b1;
          end
        end

        S_IDLE: begin
          if (any_error) begin
            st         <= S_ERROR;
            idle_out   <= 1'b0;
            error_out  <= 1'b1;
            error_fifo <= fifo_error;
          end else if (init) begin
            st       <= S_INIT;
            idle_out <= 1'b0;
          end else if (!all_empty) begin
            st         <= S_ACTIVE;
            idle_out   <= 1'b0;
            active_out <= 1'b1;
            cnt        <= 4'd0;
          end
        end

        S_ACTIVE: begin
          if (any_error) begin
            st         <= S_ERROR;
            active_out <= 1'b0;
            error_out  <= 1'b1;
            error_fifo <= fifo_error;
          end else if (init) begin
            st         <= S_INIT;
            active_out <= 1'b0;
          end else begin
            cnt <= cnt_next;
            // Leave on the very edge the quiet-cycle count hits the target.
            if (cnt_next == 4'(IDLE_CNT)) begin
              st         <= S_IDLE;
              active_out <= 1'b0;
              idle_out   <= 1'b1;
            end
          end
        end

        S_ERROR: begin
          // Absorbing: thresholds and state frozen, only new error bits accumulate.
          error_fifo <= error_fifo | fifo_error;
        end

        default: begin
          st         <= S_RESET;
          idle_out   <= 1'b0;
          active_out <= 1'b0;
          error_out  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_state_onehot: assert property (@(posedge clk) disable iff (!reset_L)
    $onehot(state));

  a_decode_match: assert property (@(posedge clk) disable iff (!reset_L)
    (idle_out == (st == S_IDLE)) && (active_out == (st == S_ACTIVE)) &&
    (error_out == (st == S_ERROR)));
`endif

endmodule

// File: tb/tb_fsm_flow_control.sv
module tb_fsm_flow_control;

  localparam int IDLE_CNT = 2;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [2:0] thr_high_in;
  logic [2:0] thr_low_in;
  logic [3:0] fifo_empty;
  logic [3:0] fifo_error;
  logic [2:0] thr_high_out;
  logic [2:0] thr_low_out;
  logic [4:0] state;
  logic       idle_out;
  logic       active_out;
  logic       error_out;
  logic [3:0] error_fifo;

  fsm_flow_control #(
    .N_FIFO(4), .THR_W(3), .THR_HIGH_RST(6), .THR_LOW_RST(1), .IDLE_CNT(IDLE_CNT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .thr_high_in(thr_high_in), .thr_low_in(thr_low_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .thr_high_out(thr_high_out), .thr_low_out(thr_low_out),
    .state(state), .idle_out(idle_out), .active_out(active_out),
    .error_out(error_out), .error_fifo(error_fifo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_chk = 0;

  // Behavioural model: state as an index (0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR)
  // plus a run-length of quiet cycles seen while active.
  int       m_idx;
  int       m_run;
  int       m_hi;
  int       m_lo;
  bit [3:0] m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_run = 0; m_hi = 6; m_lo = 1; m_err = 4'b0000;
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_idx;
    if (m_idx == 0) begin
      nxt = 1;
    end else if (m_idx == 4) begin
      m_err = m_err | fifo_error;
    end else begin
      if (m_idx == 1) begin
        m_hi = int'(thr_high_in);
        m_lo = (int'(thr_low_in) < m_hi) ? int'(thr_low_in) : m_hi;
      end
      if (fifo_error != 0) begin
        nxt = 4;
        m_err = fifo_error;
      end else if (init) begin
        nxt = 1;
      end else if (m_idx == 1) begin
        nxt = 2;
      end else if (m_idx == 2) begin
        if (fifo_empty != 4'hF) begin
          nxt = 3;
          m_run = 0;
        end
      end else begin
        m_run = (fifo_empty == 4'hF) ? ((m_run < 15) ? m_run + 1 : 15) : 0;
        if (m_run == IDLE_CNT) nxt = 2;
      end
    end
    m_idx = nxt;
  endtask

  task automatic compare_all();
    logic [4:0] exp_state;
    exp_state = 5'b00001 << m_idx;
    chk("state", 32'(state), 32'(exp_state));
    chk("thr_high_out", 32'(thr_high_out), 32'(m_hi));
    chk("thr_low_out", 32'(thr_low_out), 32'(m_lo));
    chk("idle_out", 32'(idle_out), 32'(m_idx == 2));
    chk("active_out", 32'(active_out), 32'(m_idx == 3));
    chk("error_out", 32'(error_out), 32'(m_idx == 4));
    chk("error_fifo", 32'(error_fifo), 32'(m_err));
  endtask

  always @(negedge reset_L) model_reset();

  always @(posedge clk) begin
    if (reset_L) model_step();
    #1;
    if (run_chk) compare_all();
  end

  // Advance n rising edges, then move inputs well clear of the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    reset_L = 1'b0; init = 1'b0; thr_high_in = 3'd0; thr_low_in = 3'd0;
    fifo_empty = 4'hF; fifo_error = 4'h0;
    #12;
    chk("rst_state", 32'(state), 32'h01);
    chk("rst_thr_high", 32'(thr_high_out), 32'd6);
    chk("rst_thr_low", 32'(thr_low_out), 32'd1);
    chk("rst_flags", {29'd0, idle_out, active_out, error_out}, 32'd0);
    chk("rst_error_fifo", 32'(error_fifo), 32'd0);
    run_chk = 1;

    // Bring-up: init held for two INIT edges with 5/2, then released.
    @(negedge clk);
    reset_L = 1'b1; init = 1'b1; thr_high_in = 3'd5; thr_low_in = 3'd2;
    cyc(1);
    chk("init_state", 32'(state), 32'h02);
    cyc(2);
    init = 1'b0;
    cyc(1);
    chk("idle_state", 32'(state), 32'h04);
    chk("idle_thr", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd5, 3'd2});
    chk("idle_out", 32'(idle_out), 32'd1);
    chk("model_idx_idle", 32'(m_idx), 32'd2);

    // IDLE -> ACTIVE on activity, back to IDLE exactly two quiet edges later.
    fifo_empty = 4'b1110;
    cyc(1);
    chk("active_state", 32'(state), 32'h08);
    chk("active_out", 32'(active_out), 32'd1);
    fifo_empty = 4'b1111;
    cyc(1);
    chk("quiet1_active", 32'(state), 32'h08);
    cyc(1);
    chk("quiet2_idle", 32'(state), 32'h04);

    // A one-cycle glitch restarts the quiet count.
    fifo_empty = 4'b1110;
    cyc(1);
    fifo_empty = 4'b1111;
    cyc(1);
    fifo_empty = 4'b1011;
    cyc(1);
    chk("glitch_active", 32'(state), 32'h08);
    fifo_empty = 4'b1111;
    cyc(1);
    chk("post_glitch_active", 32'(state), 32'h08);
    cyc(1);
    chk("post_glitch_idle", 32'(state), 32'h04);

    // Reload with low above high: low is clamped to high.
    init = 1'b1; thr_high_in = 3'd3; thr_low_in = 3'd6;
    cyc(1);
    chk("reinit_hold_thr", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd5, 3'd2});
    cyc(1);
    init = 1'b0;
    cyc(1);
    chk("clamp_thr", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd3, 3'd3});
    chk("model_clamp", 32'(m_lo), 32'd3);

    // init together with FIFO activity in IDLE goes to INIT.
    init = 1'b1; fifo_empty = 4'b1110; thr_high_in = 3'd7; thr_low_in = 3'd4;
    cyc(1);
    chk("init_beats_activity", 32'(state), 32'h02);
    init = 1'b0; fifo_empty = 4'b1111;
    cyc(1);
    chk("thr_7_4", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd7, 3'd4});

    // Error while active with init asserted: error wins, state is absorbing.
    fifo_empty = 4'b0111;
    cyc(1);
    fifo_error = 4'b0100; init = 1'b1;
    cyc(1);
    chk("err_state", 32'(state), 32'h10);
    chk("err_out", 32'(error_out), 32'd1);
    chk("err_fifo_0100", 32'(error_fifo), 32'h4);
    fifo_error = 4'b0000; fifo_empty = 4'b1111; thr_high_in = 3'd1; thr_low_in = 3'd0;
    cyc(2);
    init = 1'b0; fifo_empty = 4'b0000;
    cyc(1);
    chk("err_sticky_state", 32'(state), 32'h10);
    chk("err_thr_frozen", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd7, 3'd4});
    fifo_error = 4'b0001;
    cyc(1);
    chk("err_fifo_0101", 32'(error_fifo), 32'h5);
    fifo_error = 4'b0000;
    cyc(2);

    // Asynchronous reset between edges while in ERROR.
    #1;
    reset_L = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'h01);
    chk("arst_thr", {26'd0, thr_high_out, thr_low_out}, {26'd0, 3'd6, 3'd1});
    chk("arst_flags", {29'd0, idle_out, active_out, error_out}, 32'd0);
    chk("arst_error_fifo", 32'(error_fifo), 32'd0);
    cyc(2);

    // Error and init together out of IDLE.
    @(negedge clk);
    reset_L = 1'b1; init = 1'b0; fifo_empty = 4'hF; thr_high_in = 3'd6; thr_low_in = 3'd1;
    cyc(2);
    chk("restart_idle", 32'(state), 32'h04);
    fifo_error = 4'b1000; init = 1'b1;
    cyc(1);
    chk("idle_err_state", 32'(state), 32'h10);
    chk("idle_err_fifo", 32'(error_fifo), 32'h8);
    fifo_error = 4'b0000; init = 1'b0;
    cyc(2);

    run_chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
